// File: rtl/mem_access_stage.sv
// mem_access_stage: riscv32 MEM stage. Issues data-memory requests for loads and stores,
// aligns and extends load data, stalls upstream while an access is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_en_in,
  input  logic        w_en_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg_out,
  output logic        wb_en_out,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  localparam bit              TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state, state_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_load, is_store, is_mem, misaligned, accept;
  logic [3:0]       wstrb_next;
  logic [31:0]      wdata_next;
  logic [31:0]      rd_shift, load_data;
  logic             tmo_hit, store_done, load_done, abort;

  // Bundle held while the bus access is in flight
  logic [31:0]      p_pc, p_iw;
  logic [4:0]       p_reg;
  logic             p_wben;
  logic [2:0]       p_f3;
  logic [1:0]       p_off;

  always_comb begin
    opcode     = iw_in[6:0];
    funct3     = iw_in[14:12];
    is_load    = (opcode == 7'b0000011) &&
                 (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_store   = (opcode == 7'b0100011) && w_en_in &&
                 (funct3 inside {3'b000, 3'b001, 3'b010});
    is_mem     = is_load | is_store;
    misaligned = is_mem && (((funct3[1:0] == 2'b01) && alu_in[0]) ||
                            ((funct3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00)));
  end

  assign stall_out = (state != IDLE);
  assign accept    = in_valid & ~stall_out;
  assign dmem_req  = (state == REQ);

  always_comb begin
    wstrb_next = 4'b0000;
    wdata_next = rs2_data_in;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wstrb_next = 4'b0001 << alu_in[1:0];
          wdata_next = {4{rs2_data_in[7:0]}};
        end
        2'b01: begin
          wstrb_next = 4'b0011 << alu_in[1:0];
          wdata_next = {2{rs2_data_in[15:0]}};
        end
        default: wstrb_next = 4'b1111;
      endcase
    end
  end

  // Shift the addressed lane down to bit 0, then extend according to the load type
  always_comb begin
    rd_shift = dmem_rdata >> {p_off, 3'b000};
    case (p_f3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {24'h0, rd_shift[7:0]};
      3'b101:  load_data = {16'h0, rd_shift[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    store_done = 1'b0;
    load_done  = 1'b0;
    abort      = 1'b0;
    tmo_hit    = TMO_EN && (tmo_cnt == TMO_LAST);
    case (state)
      IDLE: begin
        if (accept && is_mem && !misaligned) state_next = REQ;
      end
      REQ: begin
        if (dmem_gnt) begin
          state_next = dmem_we ? IDLE : WAIT_RD;
          store_done = dmem_we;
        end else if (tmo_hit) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid) begin
          state_next = IDLE;
          load_done  = 1'b1;
        end else if (tmo_hit) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The timeout counter restarts on every state change, so each wait phase gets a full budget
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) tmo_cnt <= '0;
      else if (state != IDLE)  tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      pc_out       <= '0;
      iw_out       <= '0;
      wb_data      <= '0;
      wb_reg_out   <= '0;
      wb_en_out    <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wstrb   <= '0;
      dmem_wdata   <= '0;
      p_pc         <= '0;
      p_iw         <= '0;
      p_reg        <= '0;
      p_wben       <= 1'b0;
      p_f3         <= '0;
      p_off        <= '0;
    end else begin
      out_valid    <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      if (accept) begin
        if (!is_mem || misaligned) begin
          out_valid    <= 1'b1;
          misalign_err <= misaligned;
          pc_out       <= pc_in;
          iw_out       <= iw_in;
          wb_data      <= alu_in;
          wb_reg_out   <= wb_reg_in;
          wb_en_out    <= wb_en_in & ~misaligned;
        end else begin
          p_pc       <= pc_in;
          p_iw       <= iw_in;
          p_reg      <= wb_reg_in;
          p_wben     <= wb_en_in;
          p_f3       <= funct3;
          p_off      <= alu_in[1:0];
          dmem_we    <= is_store;
          dmem_addr  <= {alu_in[31:2], 2'b00};
          dmem_wstrb <= wstrb_next;
          dmem_wdata <= wdata_next;
        end
      end
      if (store_done || load_done || abort) begin
        out_valid  <= 1'b1;
        bus_err    <= abort;
        pc_out     <= p_pc;
        iw_out     <= p_iw;
        wb_data    <= load_done ? load_data : {dmem_addr[31:2], p_off};
        wb_reg_out <= p_reg;
        wb_en_out  <= load_done & p_wben;
      end
    end
  end

  assign df_mem_enable = out_valid & wb_en_out & (wb_reg_out != 5'd0);
  assign df_mem_reg    = wb_reg_out;
  assign df_mem_data   = wb_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized self-checking bench for the MEM stage, checked against a
// byte-lane model of RISC-V load/store semantics.
module tb_mem_access_stage;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
  logic [4:0]  wb_reg_in;
  logic        wb_en_in, w_en_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] pc_out, iw_out, wb_data;
  logic [4:0]  wb_reg_out;
  logic        wb_en_out, df_mem_enable;
  logic [4:0]  df_mem_reg;
  logic [31:0] df_mem_data;
  logic        misalign_err, bus_err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in), .iw_in(iw_in),
    .alu_in(alu_in), .rs2_data_in(rs2_data_in), .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in),
    .w_en_in(w_en_in), .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .pc_out(pc_out), .iw_out(iw_out), .wb_data(wb_data),
    .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out), .df_mem_enable(df_mem_enable),
    .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data), .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Access size in bytes from funct3
  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int sz, base;
    longint val;
    sz = ref_size(f3);
    base = int'(addr % 4);
    val = 0;
    for (int i = 0; i < sz; i++) val = val + (longint'(rdata[8*(base+i) +: 8]) << (8*i));
    if (f3[2] == 1'b0 && sz < 4 && val >= (longint'(1) << (8*sz-1))) val = val - (longint'(1) << (8*sz));
    return 32'(val);
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int a;
    s = 4'b0000;
    a = int'(addr % 4);
    for (int i = 0; i < 4; i++) if (i >= a && i < a + ref_size(f3)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    int sz;
    sz = ref_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] w;
    w = $urandom;
    w[14:12] = f3;
    w[6:0] = op;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic wben, input logic wen);
    in_valid = 1'b1; pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
    wb_reg_in = rd; wb_en_in = wben; w_en_in = wen;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; pc_in = '0; iw_in = '0; alu_in = '0; rs2_data_in = '0;
    wb_reg_in = '0; wb_en_in = 1'b0; w_en_in = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) tick();
    n_checks++;
    if ({stall_out, dmem_req, dmem_we, out_valid, misalign_err, bus_err, df_mem_enable, wb_en_out} !== 8'h00)
      $display("[TB] FAIL rst_ctrl: got %b want 00000000",
               {stall_out, dmem_req, dmem_we, out_valid, misalign_err, bus_err, df_mem_enable, wb_en_out});
    else n_pass++;
    n_checks++;
    if ({dmem_addr, dmem_wstrb, dmem_wdata} !== 68'h0)
      $display("[TB] FAIL rst_bus: got %h want 0", {dmem_addr, dmem_wstrb, dmem_wdata});
    else n_pass++;
    n_checks++;
    if ({pc_out, iw_out, wb_data, wb_reg_out, df_mem_reg, df_mem_data} !== 138'h0)
      $display("[TB] FAIL rst_fields: got %h want 0", {pc_out, iw_out, wb_data, wb_reg_out, df_mem_reg, df_mem_data});
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    repeat (2) tick();
    n_checks++;
    if (out_valid !== 1'b0 || stall_out !== 1'b0 || dmem_req !== 1'b0)
      $display("[TB] FAIL rst_stray_bus: got valid=%b stall=%b req=%b want 0 0 0", out_valid, stall_out, dmem_req);
    else n_pass++;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_nonmem();
    logic [2:0]  bad_ld [3] = '{3'd3, 3'd6, 3'd7};
    logic [31:0] pc, iw, alu;
    logic [4:0]  rd;
    logic        we, wen;
    for (int k = 0; k < 10; k++) begin
      pc = $urandom; alu = $urandom; rd = 5'($urandom_range(31, 1)); we = 1'($urandom); wen = 1'($urandom);
      case (k % 5)
        0: iw = mk_iw(7'b0110011, 3'($urandom_range(7, 0)));
        1: iw = mk_iw(7'b0010011, 3'($urandom_range(7, 0)));
        2: iw = mk_iw(7'b0000011, bad_ld[$urandom_range(2, 0)]);
        3: begin iw = mk_iw(7'b0100011, 3'($urandom_range(2, 0))); wen = 1'b0; end
        default: begin iw = mk_iw(7'b0100011, 3'($urandom_range(7, 3))); wen = 1'b1; end
      endcase
      if (k == 0) begin iw = mk_iw(7'b0110011, 3'b000); alu = 32'h0000_0010; rd = 5'd5; we = 1'b1; end
      if (k == 6) rd = 5'd0;
      drive(pc, iw, alu, $urandom, rd, we, wen);
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || stall_out !== 1'b0 || dmem_req !== 1'b0)
        $display("[TB] FAIL nm_valid[%0d]: got valid=%b stall=%b req=%b want 1 0 0", k, out_valid, stall_out, dmem_req);
      else n_pass++;
      n_checks++;
      if ({wb_data, wb_reg_out, wb_en_out, pc_out, iw_out} !== {alu, rd, we, pc, iw})
        $display("[TB] FAIL nm_fields[%0d]: got %h want %h", k, {wb_data, wb_reg_out, wb_en_out, pc_out, iw_out},
                 {alu, rd, we, pc, iw});
      else n_pass++;
      n_checks++;
      if ({df_mem_enable, df_mem_reg, df_mem_data} !== {we && (rd != 5'd0), rd, alu})
        $display("[TB] FAIL nm_fwd[%0d]: got %h want %h", k, {df_mem_enable, df_mem_reg, df_mem_data},
                 {we && (rd != 5'd0), rd, alu});
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || df_mem_enable !== 1'b0 || wb_data !== alu || stall_out !== 1'b0)
        $display("[TB] FAIL nm_pulse[%0d]: got valid=%b fwd=%b data=%h want 0 0 %h", k, out_valid, df_mem_enable, wb_data, alu);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] alu, rdata, addr;
    for (int i = 0; i < 5; i++) begin
      alu = $urandom;
      drive($urandom, mk_iw(7'b0010011, 3'b000), alu, $urandom, 5'd7, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || wb_data !== alu)
        $display("[TB] FAIL b2b_nm[%0d]: got valid=%b data=%h want 1 %h", i, out_valid, wb_data, alu);
      else n_pass++;
    end
    addr = {$urandom, 2'b00} >> 2;
    addr[1:0] = 2'b00;
    rdata = $urandom;
    drive($urandom, mk_iw(7'b0000011, 3'b010), addr, $urandom, 5'd9, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || stall_out !== 1'b1 || dmem_addr !== addr)
      $display("[TB] FAIL b2b_ld_accept: got valid=%b stall=%b addr=%h want 0 1 %h", out_valid, stall_out, dmem_addr, addr);
    else n_pass++;
    dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = rdata; tick(); dmem_rvalid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== rdata || wb_reg_out !== 5'd9)
      $display("[TB] FAIL b2b_ld_done: got valid=%b data=%h rd=%0d want 1 %h 9", out_valid, wb_data, wb_reg_out, rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_load();
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    logic [31:0] addr, rdata, pc, iw, exp;
    logic [4:0]  rd;
    logic        we;
    int          sz;
    for (int k = 0; k < 12; k++) begin
      case (k)
        0: begin f3 = 3'b000; addr = 32'h0000_1003; rdata = 32'h80FF_1234; end
        1: begin f3 = 3'b101; addr = 32'h0000_2002; rdata = 32'h9ABC_5678; end
        2: begin f3 = 3'b001; addr = 32'h0000_2002; rdata = 32'h9ABC_5678; end
        default: begin f3 = ld_f3[$urandom_range(4, 0)]; addr = $urandom; rdata = $urandom; end
      endcase
      sz = ref_size(f3);
      addr = addr - (addr % sz);
      exp = (k == 0) ? 32'hFFFF_FF80 : (k == 1) ? 32'h0000_9ABC : (k == 2) ? 32'hFFFF_9ABC
                     : ref_load(f3, addr, rdata);
      pc = $urandom; iw = mk_iw(7'b0000011, f3); rd = 5'($urandom_range(31, 0)); we = 1'b1;
      drive(pc, iw, addr, $urandom, rd, we, 1'b0);
      tick();
      in_valid = 1'b0;
      n_checks++;
      if ({stall_out, dmem_req, dmem_we, dmem_wstrb, out_valid} !== 8'b1100_0000 || dmem_addr !== (addr & 32'hFFFF_FFFC))
        $display("[TB] FAIL ld_req[%0d]: got ctl=%b addr=%h want 11000000 %h", k,
                 {stall_out, dmem_req, dmem_we, dmem_wstrb, out_valid}, dmem_addr, addr & 32'hFFFF_FFFC);
      else n_pass++;
      if (k % 2 == 1) begin
        dmem_rvalid = 1'b1; dmem_rdata = $urandom; tick(); dmem_rvalid = 1'b0;
        n_checks++;
        if (dmem_req !== 1'b1 || out_valid !== 1'b0)
          $display("[TB] FAIL ld_stray_rvalid[%0d]: got req=%b valid=%b want 1 0", k, dmem_req, out_valid);
        else n_pass++;
      end
      dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
      n_checks++;
      if (dmem_req !== 1'b0 || stall_out !== 1'b1 || out_valid !== 1'b0)
        $display("[TB] FAIL ld_wait[%0d]: got req=%b stall=%b valid=%b want 0 1 0", k, dmem_req, stall_out, out_valid);
      else n_pass++;
      dmem_rvalid = 1'b1; dmem_rdata = rdata; tick(); dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      n_checks++;
      if (out_valid !== 1'b1 || stall_out !== 1'b0 || wb_data !== exp)
        $display("[TB] FAIL ld_data[%0d]: got valid=%b stall=%b data=%h want 1 0 %h", k, out_valid, stall_out, wb_data, exp);
      else n_pass++;
      n_checks++;
      if ({wb_reg_out, wb_en_out, pc_out, iw_out, df_mem_enable} !== {rd, we, pc, iw, rd != 5'd0})
        $display("[TB] FAIL ld_fields[%0d]: got %h want %h", k, {wb_reg_out, wb_en_out, pc_out, iw_out, df_mem_enable},
                 {rd, we, pc, iw, rd != 5'd0});
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || wb_data !== exp)
        $display("[TB] FAIL ld_hold[%0d]: got valid=%b data=%h want 0 %h", k, out_valid, wb_data, exp);
      else n_pass++;
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3;
    logic [31:0] addr, rs2, pc;
    int          sz, delay;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin f3 = 3'b000; addr = 32'h0000_3001; rs2 = 32'h0000_00A5; delay = 4; end
      else begin f3 = 3'($urandom_range(2, 0)); addr = $urandom; rs2 = $urandom; delay = $urandom_range(3, 0); end
      sz = ref_size(f3);
      addr = addr - (addr % sz);
      pc = $urandom;
      drive(pc, mk_iw(7'b0100011, f3), addr, rs2, 5'($urandom_range(31, 1)), 1'b1, 1'b1);
      tick();
      for (int c = 0; c <= delay; c++) begin
        n_checks++;
        if ({dmem_req, dmem_we, stall_out, out_valid} !== 4'b1110 || dmem_addr !== (addr & 32'hFFFF_FFFC) ||
            dmem_wstrb !== ref_strb(f3, addr) || dmem_wdata !== ref_wdata(f3, rs2))
          $display("[TB] FAIL st_req[%0d.%0d]: got ctl=%b addr=%h strb=%b wdata=%h want 1110 %h %b %h", k, c,
                   {dmem_req, dmem_we, stall_out, out_valid}, dmem_addr, dmem_wstrb, dmem_wdata,
                   addr & 32'hFFFF_FFFC, ref_strb(f3, addr), ref_wdata(f3, rs2));
        else n_pass++;
        if (c < delay) begin dmem_rvalid = 1'($urandom); tick(); end
      end
      dmem_rvalid = 1'b0;
      dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || wb_en_out !== 1'b0 || df_mem_enable !== 1'b0 || stall_out !== 1'b0 || pc_out !== pc)
        $display("[TB] FAIL st_done[%0d]: got valid=%b wben=%b fwd=%b stall=%b pc=%h want 1 0 0 0 %h", k,
                 out_valid, wb_en_out, df_mem_enable, stall_out, pc_out, pc);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || dmem_req !== 1'b0)
        $display("[TB] FAIL st_pulse[%0d]: got valid=%b req=%b want 0 0", k, out_valid, dmem_req);
      else n_pass++;
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  f3;
    logic [31:0] addr, pc;
    logic        st;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin st = 1'b1; f3 = 3'b010; addr = 32'h0000_4002; end
      else begin
        st = 1'($urandom); addr = $urandom;
        f3 = (k % 2 == 0) ? 3'b010 : (st ? 3'b001 : ((k % 3 == 0) ? 3'b101 : 3'b001));
        if (f3[1:0] == 2'b01) addr[0] = 1'b1;
        else addr[1:0] = 2'($urandom_range(3, 1));
      end
      pc = $urandom;
      drive(pc, mk_iw(st ? 7'b0100011 : 7'b0000011, f3), addr, $urandom, 5'($urandom_range(31, 1)), 1'b1, st);
      tick();
      in_valid = 1'b0;
      n_checks++;
      if ({misalign_err, out_valid, wb_en_out, dmem_req, stall_out, df_mem_enable} !== 6'b110000 || pc_out !== pc)
        $display("[TB] FAIL mis_err[%0d]: got %b pc=%h want 110000 %h", k,
                 {misalign_err, out_valid, wb_en_out, dmem_req, stall_out, df_mem_enable}, pc_out, pc);
      else n_pass++;
      tick();
      n_checks++;
      if ({misalign_err, out_valid, dmem_req, stall_out} !== 4'b0000)
        $display("[TB] FAIL mis_pulse[%0d]: got %b want 0000", k, {misalign_err, out_valid, dmem_req, stall_out});
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int cycles;
    for (int p = 0; p < 2; p++) begin
      drive($urandom, mk_iw(p == 0 ? 7'b0000011 : 7'b0100011, 3'b010), 32'h0000_5000, $urandom, 5'd3, 1'b1, p == 1);
      tick();
      in_valid = 1'b0;
      if (p == 0) begin dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0; end
      cycles = 0;
      while (bus_err !== 1'b1 && cycles < 3 * TMO) begin cycles++; tick(); end
      n_checks++;
      if (bus_err !== 1'b1 || cycles != TMO)
        $display("[TB] FAIL tmo_cycles[%0d]: got bus_err=%b after %0d cycles want 1 after %0d", p, bus_err, cycles, TMO);
      else n_pass++;
      n_checks++;
      if ({out_valid, wb_en_out, stall_out, dmem_req, df_mem_enable} !== 5'b10000)
        $display("[TB] FAIL tmo_abort[%0d]: got %b want 10000", p, {out_valid, wb_en_out, stall_out, dmem_req, df_mem_enable});
      else n_pass++;
      tick();
      n_checks++;
      if (bus_err !== 1'b0 || out_valid !== 1'b0)
        $display("[TB] FAIL tmo_pulse[%0d]: got bus_err=%b valid=%b want 0 0", p, bus_err, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    for (int p = 0; p < 2; p++) begin
      drive($urandom, mk_iw(7'b0000011, 3'b010), 32'h0000_6000, $urandom, 5'd4, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      if (p == 1) begin dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0; end
      n_checks++;
      if (stall_out !== 1'b1 || dmem_req !== (p == 0))
        $display("[TB] FAIL mid_pre[%0d]: got stall=%b req=%b want 1 %b", p, stall_out, dmem_req, p == 0);
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (stall_out !== 1'b0 || dmem_req !== 1'b0 || out_valid !== 1'b0)
        $display("[TB] FAIL mid_async[%0d]: got stall=%b req=%b valid=%b want 0 0 0", p, stall_out, dmem_req, out_valid);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
      for (int c = 0; c < 3; c++) begin
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || stall_out !== 1'b0 || bus_err !== 1'b0)
          $display("[TB] FAIL mid_late[%0d.%0d]: got valid=%b stall=%b bus_err=%b want 0 0 0", p, c, out_valid, stall_out, bus_err);
        else n_pass++;
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_back_to_back();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish (passed %0d of %0d)", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
